// File: rtl/ks_256.sv
// ks_256: 256x256 -> 512-bit unsigned Karatsuba multiplier. Latency 1 cycle, or 2 with KS256_PIPE_EN.
// One operand pair per cycle, no backpressure; KS256_PIPE_EN registers the top-level z0/z1/z2.

module ks_mul #(
  parameter int N      = 128,
  parameter int LEAF_W = 16
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);
  generate
    if (N <= LEAF_W) begin : g_leaf
      assign p_o = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
    end else begin : g_split
      localparam int H = N / 2;

      logic [N-1:0] z2, z0, zm;
      logic [H:0]   sa, sb;
      logic [N+1:0] mid, z1;

      assign sa = {1'b0, a_i[N-1:H]} + {1'b0, a_i[H-1:0]};
      assign sb = {1'b0, b_i[N-1:H]} + {1'b0, b_i[H-1:0]};

      ks_mul #(.N(H), .LEAF_W(LEAF_W)) u_hi  (.a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(z2));
      ks_mul #(.N(H), .LEAF_W(LEAF_W)) u_lo  (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(z0));
      ks_mul #(.N(H), .LEAF_W(LEAF_W)) u_mid (.a_i(sa[H-1:0]),  .b_i(sb[H-1:0]),  .p_o(zm));

      // The sum carries are folded back in so the middle product reuses an H-wide instance.
      assign mid = {2'b00, zm}
                 + ({(N+2){sa[H]}} & {2'b00, sb[H-1:0], {H{1'b0}}})
                 + ({(N+2){sb[H]}} & {2'b00, sa[H-1:0], {H{1'b0}}})
                 + {1'b0, sa[H] & sb[H], {N{1'b0}}};
      assign z1  = mid - {2'b00, z2} - {2'b00, z0};
      assign p_o = {z2, z0} + {{(H-2){1'b0}}, z1, {H{1'b0}}};
    end
  endgenerate
endmodule

module ks_256 #(
  parameter int LEAF_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         out_valid,
  output logic [511:0] prod
);
  logic [255:0] z2, z0, zm;
  logic [128:0] sa, sb;
  logic [257:0] mid, z1;

  assign sa = {1'b0, a[255:128]} + {1'b0, a[127:0]};
  assign sb = {1'b0, b[255:128]} + {1'b0, b[127:0]};

  ks_mul #(.N(128), .LEAF_W(LEAF_W)) u_hi  (.a_i(a[255:128]), .b_i(b[255:128]), .p_o(z2));
  ks_mul #(.N(128), .LEAF_W(LEAF_W)) u_lo  (.a_i(a[127:0]),   .b_i(b[127:0]),   .p_o(z0));
  ks_mul #(.N(128), .LEAF_W(LEAF_W)) u_mid (.a_i(sa[127:0]),  .b_i(sb[127:0]),  .p_o(zm));

  assign mid = {2'b00, zm}
             + ({258{sa[128]}} & {2'b00, sb[127:0], 128'b0})
             + ({258{sb[128]}} & {2'b00, sa[127:0], 128'b0})
             + {1'b0, sa[128] & sb[128], 256'b0};
  assign z1  = mid - {2'b00, z2} - {2'b00, z0};

  logic [255:0] fz2, fz0;
  logic [257:0] fz1;
  logic         fvld;

`ifdef KS256_PIPE_EN
  logic [255:0] z2_q, z0_q;
  logic [257:0] z1_q;
  logic         vld1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z2_q   <= '0;
      z0_q   <= '0;
      z1_q   <= '0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= in_valid;
      if (in_valid) begin
        z2_q <= z2;
        z0_q <= z0;
        z1_q <= z1;
      end
    end
  end

  assign fz2  = z2_q;
  assign fz0  = z0_q;
  assign fz1  = z1_q;
  assign fvld = vld1_q;
`else
  assign fz2  = z2;
  assign fz0  = z0;
  assign fz1  = z1;
  assign fvld = in_valid;
`endif

  logic [511:0] prod_d, prod_q;
  logic         out_valid_q;

  assign prod_d = {fz2, fz0} + {126'b0, fz1, 128'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= fvld;
      if (fvld) prod_q <= prod_d;
    end
  end

  assign prod      = prod_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_ks_256.sv
// Directed and streaming checks for ks_256; expected products come from constants or a native wide multiply.
module tb_ks_256;
`ifdef KS256_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NSTREAM = 1000;

  logic         clk, rst_n, in_valid, out_valid;
  logic [255:0] a, b;
  logic [511:0] prod;

  int total = 0;
  int bad   = 0;

  ks_256 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .prod(prod)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [255:0] x, input logic [255:0] y,
                         input logic [511:0] exp);
    a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    chk({tag, "_vld"}, 512'(out_valid), 512'd1);
    chk(tag, prod, exp);
    tick();
    chk({tag, "_pulse"}, 512'(out_valid), 512'd0);
    chk({tag, "_hold"}, prod, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [255:0] ones, p128, p255;
  logic [511:0] e_sq, e_mid, e_p256, e_2x;
  logic [511:0] expq[$];

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    ones   = {256{1'b1}};
    p128   = 256'd1 << 128;
    p255   = 256'd1 << 255;
    e_sq   = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    e_mid  = {256'b0, {128{1'b1}}, 128'b0};
    e_p256 = 512'd1 << 256;
    e_2x   = {255'b0, {256{1'b1}}, 1'b0};

    #12;
    chk("rst_vld", 512'(out_valid), 512'd0);
    chk("rst_prod", prod, 512'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld", 512'(out_valid), 512'd0);

    run_one("small", 256'hF, 256'h2, 512'h1E);
    run_one("zero", 256'd0, ones, 512'd0);
    run_one("ones_sq", ones, ones, e_sq);
    run_one("mid_carry", p128, p128 - 256'd1, e_mid);
    run_one("p255x2", p255, 256'd2, e_p256);
    run_one("ones_x2", ones, 256'd2, e_2x);
    run_one("ones_x1", ones, 256'd1, {256'b0, ones});

    // Async reset between edges while a result is held, then a held-low in_valid after release.
    run_one("pre_rst", 256'hF, 256'h2, 512'h1E);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 512'(out_valid), 512'd0);
    chk("async_rst_prod", prod, 512'd0);
    a = 256'd3; b = 256'd3; in_valid = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      chk("rel_idle_vld", 512'(out_valid), 512'd0);
      chk("rel_idle_prod", prod, 512'd0);
    end
    run_one("after_rel", 256'd3, 256'd5, 512'd15);

    // Reset mid-stream must drop in-flight results.
    for (int k = 0; k < 3; k++) begin
      a = rnd256(); b = rnd256(); in_valid = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      chk("midstream_rst_vld", 512'(out_valid), 512'd0);
    end

    for (int i = 0; i < NSTREAM + LAT; i++) begin
      if (i >= LAT) begin
        chk("stream_vld", 512'(out_valid), 512'd1);
        chk("stream_prod", prod, expq.pop_front());
      end
      if (i < NSTREAM) begin
        a = rnd256(); b = rnd256(); in_valid = 1'b1;
        expq.push_back({256'b0, a} * {256'b0, b});
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("stream_end_vld", 512'(out_valid), 512'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
